serial_parity_receiver: RTL and testbench

Serial frame receiver that checks odd parity. It receives the parity-protected 3-bit word sent by the lab's parity-generator datapath. The transmitter appends a parity bit equal to the XNOR of the data bits, so every valid frame carries an odd number of ones across data plus parity. The block deserializes start, data, parity and stop bits on a single-wire line, then presents the word with a one-cycle valid strobe and error flags.

---
 rtl/serial_parity_receiver.sv | 178 +++++++++++++++++
 tb/tb_serial_parity_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_receiver.sv
// Odd-parity serial frame receiver: start, DW data bits (LSB first), parity, stop.
// Optional saturating 8-bit error counter on output err_count when ERR_COUNT_EN is defined.
module serial_parity_receiver #(
  parameter int DW         = 3,
  parameter int BIT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          parity_err,
  output logic          frame_err,
  output logic          busy
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]    err_count
`endif
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          par_q, par_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  logic half_tick;
  logic full_tick;

  assign half_tick = (cnt_q == HALF_LAST);
  assign full_tick = (cnt_q == FULL_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (half_tick) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (full_tick) begin
          cnt_d   = '0;
          // Shift in from the top so the first (LSB) bit lands in bit 0.
          shift_d = (shift_q >> 1) | (DW'(rx) << (DW - 1));
          if (idx_q == IDX_LAST) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (full_tick) begin
          cnt_d   = '0;
          par_d   = rx;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (full_tick) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = shift_q;
          perr_d  = ~(^shift_q ^ par_q);
          ferr_d  = ~rx;
          state_d = rx ? S_IDLE : S_RECOVER;
        end
      end

      S_RECOVER: begin
        if (rx) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != S_IDLE);

`ifdef ERR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (valid_d && (perr_d || ferr_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Bench for serial_parity_receiver: vector table plus hand-written corner sequences,
// with a scoreboard of expected words and completion cycles.
module tb_serial_parity_receiver;

  localparam int DW  = 3;
  localparam int BC  = 4;
  localparam int LAT = BC / 2 + (DW + 2) * BC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [DW-1:0] data;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
`ifdef ERR_COUNT_EN
  logic [7:0]    err_count;
`endif

  serial_parity_receiver #(.DW(DW), .BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          par;
    logic          stp;
    logic [DW-1:0] e_data;
    logic          e_pe;
    logic          e_fe;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          fe;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_model = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (BC - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stp,
                            input logic [DW-1:0] e_data, input logic e_pe, input logic e_fe);
    exp_t e;
    @(negedge clk);
    e.data = e_data;
    e.pe   = e_pe;
    e.fe   = e_fe;
    e.cyc  = cyc + 1 + LAT;
    sb.push_back(e);
    rx = 1'b0;
    repeat (BC - 1) @(negedge clk);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n - 1) @(negedge clk);
  endtask

  // Scoreboard: every valid strobe must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("data", int'(data), int'(e.data));
          check("parity_err", int'(parity_err), int'(e.pe));
          check("frame_err", int'(frame_err), int'(e.fe));
          check("valid_cycle", cyc, e.cyc);
          if ((e.pe || e.fe) && err_model < 255) err_model++;
`ifdef ERR_COUNT_EN
          check("err_count", int'(err_count), err_model);
`endif
        end
      end else begin
        check("flags_without_valid", int'(parity_err | frame_err), 0);
      end
    end
  end

  initial begin
    int k;
    int wait_cnt;

    vecs[0] = '{d: 3'b101, par: 1'b1, stp: 1'b1, e_data: 3'd5, e_pe: 1'b0, e_fe: 1'b0};
    vecs[1] = '{d: 3'b101, par: 1'b0, stp: 1'b1, e_data: 3'd5, e_pe: 1'b1, e_fe: 1'b0};
    vecs[2] = '{d: 3'b110, par: 1'b0, stp: 1'b0, e_data: 3'd6, e_pe: 1'b1, e_fe: 1'b1};
    vecs[3] = '{d: 3'b000, par: 1'b1, stp: 1'b1, e_data: 3'd0, e_pe: 1'b0, e_fe: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
`ifdef ERR_COUNT_EN
    check("rst_err_count", int'(err_count), 0);
`endif
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stp,
                 vecs[i].e_data, vecs[i].e_pe, vecs[i].e_fe);
      idle(4);
`ifdef ERR_COUNT_EN
      if (i == 1) check("err_count_after_parity", int'(err_count), 1);
`endif
    end

    // Framing error followed by a long low line: must stay busy, no new frame.
    send_frame(3'b011, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = 1'b0;
      check("recover_busy", int'(busy), 1);
    end
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("recover_exit_busy", int'(busy), 0);
    idle(4);

    // False start: one low cycle only.
    @(negedge clk);
    rx = 1'b0;
    k = cyc + 1;
    @(negedge clk);
    rx = 1'b1;
    check("false_start_busy_k", int'(busy), 1);
    @(negedge clk);
    check("false_start_busy_k1", int'(busy), 1);
    @(negedge clk);
    check("false_start_idle_k2", int'(busy), 0);
    check("false_start_edge", cyc, k + 2);
    idle(8);

    // Reset asserted for edge k+12 in the middle of a frame with data 3'b110.
    @(negedge clk);
    rx = 1'b0;
    for (int j = 1; j < 12; j++) begin
      logic [DW-1:0] dv;
      dv = 3'b110;
      @(negedge clk);
      if (j / BC == 0) rx = 1'b0;
      else rx = dv[j / BC - 1];
    end
    @(negedge clk);
    check("mid_frame_busy", int'(busy), 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_parity_err", int'(parity_err), 0);
    check("mid_rst_frame_err", int'(frame_err), 0);
`ifdef ERR_COUNT_EN
    check("mid_rst_err_count", int'(err_count), 0);
`endif
    err_model = 0;
    rst = 1'b0;
    idle(3);
    send_frame(vecs[3].d, vecs[3].par, vecs[3].stp,
               vecs[3].e_data, vecs[3].e_pe, vecs[3].e_fe);
    idle(4);

    // Back-to-back frames: valid strobes exactly one frame length (24 cycles) apart.
    send_frame(3'b111, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0);
    send_frame(3'b001, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    idle(4);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
